// File: rtl/func_sim_monitor.sv
// func_sim_monitor: windowed statistics over a signed sample stream.
// Each window of N = 2^LOG2_WIN valid samples gives a registered result
// (floor mean, minimum, maximum). A result completing while the previous
// one is still unconsumed is dropped and counted (saturating).
module func_sim_monitor #(
  parameter int WIDTH    = 25,
  parameter int LOG2_WIN = 4,
  parameter int DROP_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] in_,
  input  logic                    in_valid,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [WIDTH-1:0] avg,
  output logic signed [WIDTH-1:0] min,
  output logic signed [WIDTH-1:0] max,
  output logic [DROP_W-1:0]       drop_cnt
);

  localparam int SUM_W = WIDTH + LOG2_WIN;

  // Accumulator state for the window currently being collected
  logic [LOG2_WIN-1:0]     cnt_q, cnt_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic signed [WIDTH-1:0] min_q, min_d;
  logic signed [WIDTH-1:0] max_q, max_d;

  // Result registers presented to the consumer
  logic signed [WIDTH-1:0] avg_q, avg_d;
  logic signed [WIDTH-1:0] rmin_q, rmin_d;
  logic signed [WIDTH-1:0] rmax_q, rmax_d;
  logic                    res_valid_q, res_valid_d;
  logic [DROP_W-1:0]       drop_q, drop_d;

  // Values including the current sample, shared by accumulator and result
  logic signed [SUM_W-1:0] in_ext;
  logic signed [SUM_W-1:0] sum_nx;
  logic signed [WIDTH-1:0] min_nx;
  logic signed [WIDTH-1:0] max_nx;
  logic                    first;
  logic                    complete;

  // Fold the incoming sample into the window; first sample restarts it
  always_comb begin
    in_ext   = {{LOG2_WIN{in_[WIDTH-1]}}, in_};
    first    = (cnt_q == '0);
    complete = in_valid && (cnt_q == '1);
    sum_nx   = first ? in_ext : (sum_q + in_ext);
    min_nx   = (first || (in_ < min_q)) ? in_ : min_q;
    max_nx   = (first || (in_ > max_q)) ? in_ : max_q;

    cnt_d = cnt_q;
    sum_d = sum_q;
    min_d = min_q;
    max_d = max_q;
    if (in_valid) begin
      cnt_d = cnt_q + 1'b1;
      sum_d = sum_nx;
      min_d = min_nx;
      max_d = max_nx;
    end
  end

  // Result handshake: load on completion if the slot is free or being
  // accepted now, otherwise drop and count; plain accept empties the slot
  always_comb begin
    avg_d       = avg_q;
    rmin_d      = rmin_q;
    rmax_d      = rmax_q;
    res_valid_d = res_valid_q;
    drop_d      = drop_q;
    if (complete && (!res_valid_q || res_ready)) begin
      // Upper WIDTH bits of the sum are the arithmetic shift by LOG2_WIN
      avg_d       = sum_nx[LOG2_WIN +: WIDTH];
      rmin_d      = min_nx;
      rmax_d      = max_nx;
      res_valid_d = 1'b1;
    end else begin
      if (complete && (drop_q != '1)) begin
        drop_d = drop_q + 1'b1;
      end
      if (res_valid_q && res_ready) begin
        res_valid_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      sum_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      avg_q       <= '0;
      rmin_q      <= '0;
      rmax_q      <= '0;
      res_valid_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      min_q       <= min_d;
      max_q       <= max_d;
      avg_q       <= avg_d;
      rmin_q      <= rmin_d;
      rmax_q      <= rmax_d;
      res_valid_q <= res_valid_d;
      drop_q      <= drop_d;
    end
  end

  assign avg       = avg_q;
  assign min       = rmin_q;
  assign max       = rmax_q;
  assign res_valid = res_valid_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_func_sim_monitor.sv
// Self-checking bench for func_sim_monitor: three instances with window
// lengths 16, 4 and 2; a vector table on the N=4 instance plus directed
// sequences for handshake, drop, saturation and reset corner cases.
module tb_func_sim_monitor;

  localparam int W = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // N=16 instance (a_*)
  logic signed [W-1:0] a_in, a_avg, a_min, a_max;
  logic a_v, a_rdy, a_rv;
  logic [7:0] a_drop;

  // N=4 instance with 2-bit drop counter (b_*)
  logic signed [W-1:0] b_in, b_avg, b_min, b_max;
  logic b_v, b_rdy, b_rv;
  logic [1:0] b_drop;

  // N=2 instance (c_*)
  logic signed [W-1:0] c_in, c_avg, c_min, c_max;
  logic c_v, c_rdy, c_rv;
  logic [7:0] c_drop;

  func_sim_monitor #(.WIDTH(W), .LOG2_WIN(4), .DROP_W(8)) u16 (
    .clk(clk), .rst_n(rst_n), .in_(a_in), .in_valid(a_v),
    .res_valid(a_rv), .res_ready(a_rdy),
    .avg(a_avg), .min(a_min), .max(a_max), .drop_cnt(a_drop)
  );

  func_sim_monitor #(.WIDTH(W), .LOG2_WIN(2), .DROP_W(2)) u4 (
    .clk(clk), .rst_n(rst_n), .in_(b_in), .in_valid(b_v),
    .res_valid(b_rv), .res_ready(b_rdy),
    .avg(b_avg), .min(b_min), .max(b_max), .drop_cnt(b_drop)
  );

  func_sim_monitor #(.WIDTH(W), .LOG2_WIN(1), .DROP_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .in_(c_in), .in_valid(c_v),
    .res_valid(c_rv), .res_ready(c_rdy),
    .avg(c_avg), .min(c_min), .max(c_max), .drop_cnt(c_drop)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one full N=16 window of a constant value, ready held at rdy
  task automatic win16(input int val, input logic rdy);
    a_rdy = rdy;
    for (int i = 0; i < 16; i++) begin
      a_v  = 1'b1;
      a_in = W'(val);
      tick();
    end
    a_v = 1'b0;
  endtask

  // Push one full N=4 window of a constant value with ready low
  task automatic win4(input int val);
    b_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_v  = 1'b1;
      b_in = W'(val);
      tick();
    end
    b_v = 1'b0;
  endtask

  typedef struct {
    int s0, s1, s2, s3;
    int e_avg, e_min, e_max;
  } vec_t;

  vec_t tbl[7];

  initial begin
    // N=4 windows, hand-computed floor mean / min / max
    tbl[0] = '{1, 2, 3, 4, 2, 1, 4};
    tbl[1] = '{-1, -1, -1, -2, -2, -2, -1};
    tbl[2] = '{100, -100, 50, -50, 0, -100, 100};
    tbl[3] = '{16777215, 16777215, 16777215, 16777215, 16777215, 16777215, 16777215};
    tbl[4] = '{-16777216, -16777216, -16777216, -16777216, -16777216, -16777216, -16777216};
    tbl[5] = '{5, 6, 7, 8, 6, 5, 8};
    tbl[6] = '{-3, 0, 0, 0, -1, -3, 0};

    a_in = '0; a_v = 1'b0; a_rdy = 1'b0;
    b_in = '0; b_v = 1'b0; b_rdy = 1'b0;
    c_in = '0; c_v = 1'b0; c_rdy = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();

    chk("reset_rv",   a_rv,   0);
    chk("reset_avg",  a_avg,  0);
    chk("reset_min",  a_min,  0);
    chk("reset_max",  a_max,  0);
    chk("reset_drop", a_drop, 0);
    rst_n = 1'b1;
    tick();

    // Basic window 0..15 on N=16
    for (int i = 0; i < 16; i++) begin
      a_v  = 1'b1;
      a_in = W'(i);
      tick();
      if (i == 14) chk("basic_early_rv", a_rv, 0);
    end
    a_v = 1'b0;
    chk("basic_rv",  a_rv,  1);
    chk("basic_avg", a_avg, 7);
    chk("basic_min", a_min, 0);
    chk("basic_max", a_max, 15);
    a_rdy = 1'b1;
    tick();
    a_rdy = 1'b0;
    chk("basic_accept_rv", a_rv, 0);

    // Signed floor on N=2
    c_v = 1'b1; c_in = -1; tick();
    c_in = -2; tick();
    c_v = 1'b0;
    chk("floor_rv",  c_rv,  1);
    chk("floor_avg", c_avg, -2);
    chk("floor_min", c_min, -2);
    chk("floor_max", c_max, -1);

    // Gaps on N=4: valid on even cycles only
    for (int i = 0; i < 8; i++) begin
      b_v  = (i % 2 == 0);
      b_in = 4;
      tick();
      if (i == 5) chk("gap_early_rv", b_rv, 0);
      if (i == 6) begin
        chk("gap_rv",  b_rv,  1);
        chk("gap_avg", b_avg, 4);
      end
    end
    b_v = 1'b0;
    b_rdy = 1'b1; tick(); b_rdy = 1'b0;
    chk("gap_accept_rv", b_rv, 0);

    // Table-driven windows on N=4
    for (int k = 0; k < 7; k++) begin
      b_v = 1'b1;
      b_in = W'(tbl[k].s0); tick();
      b_in = W'(tbl[k].s1); tick();
      b_in = W'(tbl[k].s2); tick();
      b_in = W'(tbl[k].s3); tick();
      b_v = 1'b0;
      chk($sformatf("vec%0d_rv", k),  b_rv,  1);
      chk($sformatf("vec%0d_avg", k), b_avg, tbl[k].e_avg);
      chk($sformatf("vec%0d_min", k), b_min, tbl[k].e_min);
      chk($sformatf("vec%0d_max", k), b_max, tbl[k].e_max);
      b_rdy = 1'b1; tick(); b_rdy = 1'b0;
      chk($sformatf("vec%0d_acc", k), b_rv, 0);
    end
    chk("vec_drop", b_drop, 0);

    // Drop-counter saturation on N=4 (2-bit counter): 5 windows, 4 drops
    for (int w = 0; w < 5; w++) win4(7 + w);
    chk("sat_drop", b_drop, 3);
    chk("sat_avg",  b_avg,  7);
    chk("sat_rv",   b_rv,   1);

    // Drops on N=16: three windows, ready low
    for (int w = 0; w < 3; w++) win16(w + 1, 1'b0);
    chk("drop_rv",   a_rv,   1);
    chk("drop_avg",  a_avg,  1);
    chk("drop_min",  a_min,  1);
    chk("drop_max",  a_max,  1);
    chk("drop_cnt",  a_drop, 2);
    a_rdy = 1'b1; tick(); a_rdy = 1'b0;
    chk("drop_accept_rv",   a_rv,   0);
    chk("drop_accept_cnt",  a_drop, 2);

    // Completion coinciding with acceptance
    win16(5, 1'b0);
    chk("sim_first_avg", a_avg, 5);
    for (int i = 0; i < 16; i++) begin
      a_v   = 1'b1;
      a_in  = 9;
      a_rdy = (i == 15);
      tick();
      if (i == 7) chk("sim_hold_avg", a_avg, 5);
    end
    a_v = 1'b0; a_rdy = 1'b0;
    chk("sim_rv",   a_rv,   1);
    chk("sim_avg",  a_avg,  9);
    chk("sim_drop", a_drop, 2);

    // Mid-window reset after 5 of 16 samples
    for (int i = 0; i < 5; i++) begin
      a_v = 1'b1; a_in = 100; tick();
    end
    a_v = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("mrst_rv",   a_rv,   0);
    chk("mrst_avg",  a_avg,  0);
    chk("mrst_min",  a_min,  0);
    chk("mrst_max",  a_max,  0);
    chk("mrst_drop", a_drop, 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      a_v = 1'b1; a_in = 3; tick();
      if (i == 14) chk("mrst_early_rv", a_rv, 0);
    end
    a_v = 1'b0;
    chk("mrst_rv2", a_rv,  1);
    chk("mrst_avg2", a_avg, 3);
    chk("mrst_min2", a_min, 3);
    chk("mrst_max2", a_max, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/func_sim_monitor.md
FUNC_SIM_MONITOR -- requirements
Module: func_sim_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 25, bit width of the signed fixed-point sample, matching the model output format.
REQ-002 SHALL have parameter LOG2_WIN, default 4, giving a window length N = 2^LOG2_WIN samples; legal range 1..8.
REQ-003 SHALL have parameter DROP_W, default 8, giving the width of the dropped-result counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_, input, WIDTH bits, signed fixed-point sample from the model output (out_int).
REQ-007 SHALL have port in_valid, input, 1 bit: in_ is sampled on this cycle.
REQ-008 SHALL have port res_valid, output, 1 bit: the result registers hold an unconsumed window result.
REQ-009 SHALL have port res_ready, input, 1 bit: the consumer accepts the result when res_valid and res_ready are both high.
REQ-010 SHALL have port avg, output, WIDTH bits, signed window mean.
REQ-011 SHALL have port min, output, WIDTH bits, signed window minimum.
REQ-012 SHALL have port max, output, WIDTH bits, signed window maximum.
REQ-013 SHALL have port drop_cnt, output, DROP_W bits, unsigned count of results discarded because the result register was still occupied.

Function
REQ-014 SHALL accumulate only on cycles where in_valid=1; cycles with in_valid=0 leave all accumulator state unchanged.
REQ-015 SHALL keep the running sum in WIDTH+LOG2_WIN signed bits so the sum can never overflow.
REQ-016 SHALL keep a sample counter of LOG2_WIN bits that wraps from N-1 to 0.
REQ-017 SHALL, on the first sample of a window (counter=0), load sum, min and max directly from in_ and discard the previous window's values.
REQ-018 SHALL, on later samples, compute sum+=in_, min=smaller of (min, in_), max=larger of (max, in_), using signed compares.
REQ-019 SHALL treat the sample with counter=N-1 as window completion and form the result from the state including that sample.
REQ-020 SHALL compute avg as the final sum arithmetically shifted right by LOG2_WIN bits (floor toward minus infinity), truncated to WIDTH bits; truncation is lossless by construction.
REQ-021 SHALL register the result, so avg, min, max and res_valid update on the clock edge after the completing sample (latency 1 cycle).
REQ-022 SHALL hold avg, min, max stable while res_valid=1 and the result has not been accepted.
REQ-023 SHALL clear res_valid on the edge where res_valid=1 and res_ready=1, unless a new window completes on that same cycle.
REQ-024 SHALL, when completion coincides with acceptance, load the new result and keep res_valid=1; no drop is counted.
REQ-025 SHALL, when completion occurs with res_valid=1 and res_ready=0, keep the old result, discard the new one, and increment drop_cnt.
REQ-026 SHALL saturate drop_cnt at 2^DROP_W-1; it never wraps.
REQ-027 SHALL continue accumulating the next window independently of the output handshake; the input is never back-pressured.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force the counter, sum, min, max, avg and drop_cnt to 0 and res_valid to 0.
REQ-029 SHALL, on reset asserted mid-window, discard the partial window; the first in_valid after rst_n deasserts starts a new window with counter=0.
REQ-030 SHALL deassert reset synchronously to clk, supplied externally; the block adds no internal synchronizer.

Verification
REQ-031 SHALL be covered by a bench case for the basic window: N=16, samples 0..15 with in_valid=1 continuously -> one cycle after the 16th sample, res_valid=1, avg=7, min=0, max=15.
REQ-032 SHALL be covered by a bench case for signed floor: N=2, samples -1 and -2 -> avg=-2, min=-2, max=-1.
REQ-033 SHALL be covered by a bench case for gaps: N=4, samples 4,4,4,4 with in_valid low on alternate cycles -> avg=4, with completion only on the 4th valid sample.
REQ-034 SHALL be covered by a bench case for drops: res_ready held 0 for 3 windows -> the first result is retained, drop_cnt=2; one accept clears res_valid.
REQ-035 SHALL be covered by a bench case for simultaneous completion and accept on the same cycle -> the new result is visible on the next edge, res_valid stays 1, drop_cnt is unchanged.
REQ-036 SHALL be covered by a bench case for mid-window reset: rst_n pulsed low after 5 of 16 samples -> all outputs 0; the next 16 samples of value 3 give avg=3.
